mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port to one-port arbiter for the unified instruction/data SRAM of the rvseed core. It shares one single-port synchronous memory between instruction fetch and the load/store unit. It issues at most one access per cycle and routes each one-cycle-latency response back to the requester that owns it. It sits between the core's fetch/LSU request ports and the memory macro that the bench preloads.

## Interface
- AW, 32, byte address width
- DW, `CPU_WIDTH (32), data width
- MAX_WAIT, 4, consecutive fetch denials before fetch is force-granted (used only with MEM_ARB_AGE_EN)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request (read only)
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  fetch data valid (cycle after grant)
- if_rdata  out  DW  fetch data
- d_req  in  1  load/store request
- d_we  in  1  1 = store
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_wstrb  in  DW/8  store byte enables
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  load data / store ack valid (cycle after grant)
- d_rdata  out  DW  load data; 0 on store ack
- mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/1/AW/DW/DW/8  memory command
- mem_rdata  in  DW  memory read data, valid one cycle after mem_en with mem_we=0

## Operation
- Each cycle, select at most one requester. Drive mem_* combinationally from the winner. Assert only the winner's gnt.
- Default priority: data beats fetch, so the LSU never stalls behind fetch.
- Only one requester: it wins.
- Neither requester: mem_en=0, mem_we=0, mem_addr/wdata/wstrb=0.
- Owner register rsp_sel ∈ {NONE, IF, D}. Loaded at each edge with the cycle's winner, or NONE if there is no grant.
- rsp_sel=IF: if_rvalid=1, if_rdata=mem_rdata.
- rsp_sel=D: d_rvalid=1. d_rdata=mem_rdata for loads, 0 for stores (stored-we flag).
- Non-owner rdata outputs are 0.
- A requester holds req and its request fields stable until gnt. After gnt it may present a new request in the same cycle that the previous rvalid is seen, so back-to-back grants sustain one access per cycle.
- A request dropped before gnt is legal. No state is retained for it.
- Addresses pass through unmodified. Alignment is the requester's responsibility.

## Timing
- Grant: 0 cycles (same cycle as req). Response: exactly 1 cycle after grant.
- Reset values: rsp_sel=NONE, wait counter=0, all rvalid=0, all rdata=0, if_gnt=d_gnt=0 while rst=1, mem_en=0 while rst=1.
- Reset mid-operation: an in-flight response is discarded. No rvalid in the cycle after reset deasserts, unless a grant occurred in the first post-reset cycle.
- Simultaneous d_req and if_req: one grant only. The loser's gnt=0 and its request stays pending.
- The rsp_sel path is fully registered. There is no combinational path from mem_rdata to any gnt.

## Configuration
- MEM_ARB_AGE_EN defined: a saturating counter wait_cnt (width clog2(MAX_WAIT+1)).
  - Increments on each cycle with if_req=1 and if_gnt=0.
  - Clears on if_gnt or !if_req.
  - When wait_cnt==MAX_WAIT, fetch wins over data for that cycle, then the counter clears.
- MEM_ARB_AGE_EN not defined: strict data priority with no counter. Fetch may starve indefinitely.

## Structure
- Add the following to the shared rvseed_defines.v:
  - Owner encodings: `RSP_NONE=2'd0, `RSP_IF=2'd1, `RSP_D=2'd2.
  - `MEM_AW.
- Use the existing `CPU_WIDTH.
- Single module. The only natural sub-block is the age counter, kept inline under the ifdef. No sub-module.

## Test plan
- Fetch only:
  - Stimulus: if_req=1, addr 0x0/0x4/0x8 on consecutive cycles, memory preloaded 0x00000013 / 0x00100093 / 0x00200113.
  - Response: if_gnt=1 every cycle, if_rvalid on cycles 1–3 with those words in order.
- Collision:
  - Stimulus: if_req and d_req (load 0x100, content 0xDEADBEEF) in the same cycle.
  - Response: d_gnt=1, if_gnt=0. Next cycle: d_rdata=0xDEADBEEF and if_gnt=1.
- Store ack:
  - Stimulus: d_we=1, addr 0x200, wdata 0x12345678, wstrb 4'b0011. Then load 0x200 (prior content 0).
  - Response: d_rvalid with d_rdata=0 on the store ack. The load returns 0x00005678.
- Age guard:
  - Stimulus: MEM_ARB_AGE_EN defined, MAX_WAIT=4, d_req and if_req held high continuously.
  - Response: d_gnt for 4 cycles, if_gnt on the 5th, pattern repeats.
  - Without the macro: if_gnt never asserts.
- Reset mid-flight:
  - Stimulus: rst=1 in the cycle after a fetch grant.
  - Response: if_rvalid=0 and rdata=0 while reset is asserted. No stale response after release.
- Idle:
  - Stimulus: no requests for 10 cycles.
  - Response: mem_en=0, both gnt and rvalid=0 throughout.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the rvseed unified-SRAM arbiter: response owner codes and memory address width.
// CPU_WIDTH falls back to 32 when the core-wide define is not already present.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef MEM_AW
`define MEM_AW 32
`endif
`ifndef RSP_NONE
`define RSP_NONE 2'd0
`endif
`ifndef RSP_IF
`define RSP_IF 2'd1
`endif
`ifndef RSP_D
`define RSP_D 2'd2
`endif

package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    RSP_NONE = `RSP_NONE,
    RSP_IF   = `RSP_IF,
    RSP_D    = `RSP_D
  } rsp_sel_e;

  localparam int MEM_AW = `MEM_AW;

endpackage

// File: rtl/mem_arbiter.sv
// Fetch/LSU to single-port SRAM arbiter: data has priority, responses routed by a registered owner tag.
// Define MEM_ARB_AGE_EN to force a fetch grant after MAX_WAIT consecutive fetch denials.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW       = MEM_AW,
  parameter int DW       = `CPU_WIDTH,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic [DW-1:0]   mem_rdata
);

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("mem_arbiter: MAX_WAIT must be at least 1");
  end

  rsp_sel_e rsp_sel_q, rsp_sel_d;
  logic     d_we_q, d_we_d;
  logic     age_hit;

`ifdef MEM_ARB_AGE_EN
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  assign age_hit = (wait_cnt_q == CW'(MAX_WAIT));

  // Counts consecutive cycles fetch was asking but lost; saturates at MAX_WAIT.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (if_gnt || !if_req) begin
      wait_cnt_d = '0;
    end else if (!age_hit) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign age_hit = 1'b0;
`endif

  // Grant selection and memory command; everything idles to zero while in reset.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    rsp_sel_d = RSP_NONE;
    d_we_d    = 1'b0;
    if (!rst) begin
      if (if_req && (!d_req || age_hit)) begin
        if_gnt    = 1'b1;
        mem_en    = 1'b1;
        mem_addr  = if_addr;
        rsp_sel_d = RSP_IF;
      end else if (d_req) begin
        d_gnt     = 1'b1;
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_wstrb = d_wstrb;
        rsp_sel_d = RSP_D;
        d_we_d    = d_we;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_sel_q <= RSP_NONE;
      d_we_q    <= 1'b0;
    end else begin
      rsp_sel_q <= rsp_sel_d;
      d_we_q    <= d_we_d;
    end
  end

  // Responses are masked during reset so an in-flight access never leaks out.
  assign if_rvalid = !rst && (rsp_sel_q == RSP_IF);
  assign d_rvalid  = !rst && (rsp_sel_q == RSP_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid && !d_we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter with an SRAM model and a behavioural reference.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_WAIT = 4;
`ifdef MEM_ARB_AGE_EN
  localparam bit AGE = 1'b1;
`else
  localparam bit AGE = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_wstrb;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [DW-1:0] mem_rdata;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro: 4 KiB, one-cycle read latency, byte-strobed writes, backdoor loader.
  logic [31:0] mem [0:1023];
  logic        ld_en;
  logic [9:0]  ld_idx;
  logic [31:0] ld_val;

  always @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_val;
    if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[11:2]];
    else                   mem_rdata <= $urandom;
  end

  // Reference state
  logic [31:0] ref_mem [0:1023];
  int          denied;
  int          exp_owner;
  logic [31:0] exp_rdata;
  logic        last_if_gnt;
  int          checks;
  int          failures;
  int          gnt_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs already driven; check mid-cycle, then advance the reference at the edge.
  task automatic cycle();
    int win;
    logic [31:0] ea;
    #3;
    win = 0;
    if (!rst) begin
      if (if_req && (!d_req || (AGE && denied >= MAX_WAIT))) win = 1;
      else if (d_req) win = 2;
    end
    ea = (win == 1) ? if_addr : (win == 2) ? d_addr : 32'h0;
    chk("if_gnt", 32'(if_gnt), 32'(win == 1));
    chk("d_gnt", 32'(d_gnt), 32'(win == 2));
    chk("mem_en", 32'(mem_en), 32'(win != 0));
    chk("mem_we", 32'(mem_we), 32'(win == 2 && d_we));
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, (win == 2) ? d_wdata : 32'h0);
    chk("mem_wstrb", 32'(mem_wstrb), (win == 2) ? 32'(d_wstrb) : 32'h0);
    chk("if_rvalid", 32'(if_rvalid), 32'(!rst && exp_owner == 1));
    chk("if_rdata", if_rdata, (!rst && exp_owner == 1) ? exp_rdata : 32'h0);
    chk("d_rvalid", 32'(d_rvalid), 32'(!rst && exp_owner == 2));
    chk("d_rdata", d_rdata, (!rst && exp_owner == 2) ? exp_rdata : 32'h0);
    last_if_gnt = if_gnt;
    @(posedge clk);
    if (rst) begin
      exp_owner = 0;
      denied    = 0;
    end else begin
      exp_owner = win;
      if (win == 1) exp_rdata = ref_mem[if_addr[11:2]];
      else if (win == 2) begin
        if (d_we) begin
          exp_rdata = 32'h0;
          for (int b = 0; b < 4; b++)
            if (d_wstrb[b]) ref_mem[d_addr[11:2]][8*b +: 8] = d_wdata[8*b +: 8];
        end else begin
          exp_rdata = ref_mem[d_addr[11:2]];
        end
      end
      if (win == 1 || !if_req) denied = 0;
      else if (denied < MAX_WAIT) denied++;
    end
    #1;
  endtask

  task automatic set_idle();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
  endtask

  task automatic set_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_wstrb = st;
  endtask

  initial begin
    checks = 0; failures = 0; denied = 0; exp_owner = 0; exp_rdata = '0;
    last_if_gnt = 1'b0; gnt_cnt = 0;
    rst = 1'b1; ld_en = 1'b0; ld_idx = '0; ld_val = '0;
    set_idle();

    // Preload through the backdoor while the arbiter sits in reset
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] v;
      v = $urandom;
      case (i)
        0:       v = 32'h0000_0013;
        1:       v = 32'h0010_0093;
        2:       v = 32'h0020_0113;
        'h40:    v = 32'hDEAD_BEEF;
        'h80:    v = 32'h0;
        default: ;
      endcase
      ref_mem[i] = v;
      @(negedge clk);
      ld_en = 1'b1; ld_idx = 10'(i); ld_val = v;
      @(posedge clk); #1;
    end
    ld_en = 1'b0;

    // Reset holds grants and memory command low even with requests present
    if_req = 1'b1; if_addr = 32'h4; set_d(1'b0, 32'h8, 32'h0, 4'h0);
    cycle();
    cycle();
    rst = 1'b0;
    set_idle();
    cycle();

    // Fetch only, three back-to-back words
    if_req = 1'b1; if_addr = 32'h0; cycle();
    chk("fetch0_data", if_rdata, 32'h0000_0013);
    if_addr = 32'h4; cycle();
    chk("fetch1_data", if_rdata, 32'h0010_0093);
    if_addr = 32'h8; cycle();
    chk("fetch2_data", if_rdata, 32'h0020_0113);
    set_idle(); cycle();

    // Collision: data wins, fetch is served next cycle
    if_req = 1'b1; if_addr = 32'hC; set_d(1'b0, 32'h100, 32'h0, 4'h0);
    cycle();
    chk("coll_d_rdata", d_rdata, 32'hDEAD_BEEF);
    d_req = 1'b0;
    cycle();
    chk("coll_if_gnt_next", 32'(last_if_gnt), 32'h1);
    set_idle(); cycle();

    // Store ack then read back a half-word update
    set_d(1'b1, 32'h200, 32'h1234_5678, 4'b0011);
    cycle();
    chk("store_ack_valid", 32'(d_rvalid), 32'h1);
    chk("store_ack_data", d_rdata, 32'h0);
    set_d(1'b0, 32'h200, 32'h0, 4'h0);
    cycle();
    chk("store_readback", d_rdata, 32'h0000_5678);
    set_idle(); cycle();

    // Both held high: aging lets fetch in every fifth cycle, otherwise never
    if_req = 1'b1; if_addr = 32'h10; set_d(1'b0, 32'h300, 32'h0, 4'h0);
    gnt_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (last_if_gnt) gnt_cnt++;
    end
    chk("age_if_gnt_count", 32'(gnt_cnt), AGE ? 32'd2 : 32'd0);
    set_idle(); cycle();

    // Reset in the cycle after a fetch grant
    if_req = 1'b1; if_addr = 32'h4; cycle();
    rst = 1'b1; cycle();
    rst = 1'b0; set_idle(); cycle();
    chk("rst_no_stale", 32'(if_rvalid), 32'h0);

    // Idle stretch
    for (int i = 0; i < 10; i++) cycle();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 39) == 0);
      if_req  = ($urandom_range(0, 9) < 7);
      if_addr = {20'h0, 10'($urandom), 2'b00};
      if ($urandom_range(0, 9) < 6) begin
        if ($urandom_range(0, 1) == 1)
          set_d(1'b1, {20'h0, 10'($urandom), 2'b00}, $urandom, 4'($urandom));
        else
          set_d(1'b0, {20'h0, 10'($urandom), 2'b00}, 32'h0, 4'h0);
      end else begin
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
      end
      cycle();
    end
    rst = 1'b0; set_idle(); cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
